seven_segment_scanner: RTL

Time-multiplexed controller for a common-anode, multi-digit seven-segment display.
- Holds a NUM_DIGITS-nibble display value and scans the digits one at a time onto a single shared active-low segment bus.
- Inserts an all-off guard interval between digits to suppress ghosting.
- Applies new data only at frame boundaries, so a displayed value never tears.
- Sits between the datapath that produces hex values and the board's SEG/DP/AN pins.

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/seven_segment_display.sv | 14 +
 rtl/seven_segment_scanner.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Contents:
//   seg_t      - 7-bit segment vector, bit order g..a, active-low
//   SEG_BLANK  - all segments off
//   HEX_SEG    - 16-entry hex-to-segment table (active-low)
//   state_t    - scanner slot phase {GUARD, SHOW}
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seven_segment_display.sv
// 4-bit hex to active-low seven-segment decoder.
// Ports:
//   hex - nibble to display
//   seg - segments g..a, active-low
module seven_segment_display
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner.
// Each digit slot is REFRESH_DIV cycles: GUARD_CYCLES with all anodes off,
// then the digit is shown. New data is staged in a shadow set and moved to
// the active set only at the end of the last digit's slot, so a frame never
// mixes old and new digits.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load        - one-cycle strobe capturing data/dp_in/blank_in
//   data        - NUM_DIGITS hex nibbles, digit 0 in bits [3:0]
//   dp_in       - decimal point request per digit (active-high)
//   blank_in    - forced blank per digit (active-high)
//   lz_en       - leading-zero blanking enable (live level)
//   seg, dp, an - active-low display pins, registered
//   frame_done  - one-cycle pulse during the final cycle of each frame
//
// state | meaning
// GUARD | all anodes off, segments off; anti-ghosting gap at slot start
// SHOW  | anode idx low, segments show active nibble idx
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output seg_t                    seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  // frame_done is registered, so it is raised one cycle ahead of the last cycle
  localparam logic [CNT_W-1:0] FD_PRE     = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic [3:0]              nibble;
  seg_t                    seg_dec;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    all_zero;
  logic                    blank_now;
  logic                    slot_end;
  logic                    boundary;

  assign nibble = act_data[{idx, 2'b00} +: 4];

  seven_segment_display u_dec (
    .hex (nibble),
    .seg (seg_dec)
  );

  // lz_mask[i] is set when nibble i and every nibble above it are zero;
  // digit 0 is excluded so a zero value still shows "0".
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (act_data[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero;
    end
  end

  assign blank_now = act_blank[idx] | (lz_en & lz_mask[idx]);
  assign slot_end  = (cnt == CNT_LAST);
  assign boundary  = (state == SHOW) && slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GUARD;
      cnt          <= '0;
      idx          <= '0;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
      an           <= '1;
      frame_done   <= 1'b0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      pending      <= 1'b0;
      act_data     <= '0;
      act_dp       <= '0;
      act_blank    <= '0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CNT_W'(1);
      frame_done <= (cnt == FD_PRE) && (idx == IDX_LAST);

      case (state)
        GUARD: begin
          if (cnt == GUARD_LAST) begin
            state <= SHOW;
            an    <= ~(NUM_DIGITS'(1) << idx);
            seg   <= blank_now ? SEG_BLANK : seg_dec;
            dp    <= ~act_dp[idx];
          end
        end
        SHOW: begin
          if (slot_end) begin
            state <= GUARD;
            an    <= '1;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          end
        end
        default: state <= GUARD;
      endcase

      if (load) begin
        shadow_data  <= data;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end

      // A load on the boundary bypasses straight to the active set.
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          act_data  <= data;
          act_dp    <= dp_in;
          act_blank <= blank_in;
        end else if (pending) begin
          act_data  <= shadow_data;
          act_dp    <= shadow_dp;
          act_blank <= shadow_blank;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
